pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage RISC-V core (pc_reg, if_id, id_ex, ex_mem, mem_wb).

---
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, multi-cycle EX sequencing,
// branch flush/redirect and debug halt/drain/resume.
module pipe_ctrl #(
    parameter int MC_W      = 6,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallreq_id_i,
    input  logic             mc_start_i,
    input  logic [MC_W-1:0]  mc_cycles_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_target_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic [4:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             mc_done_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        MC_BUSY,
        HALT_DRAIN,
        HALTED
    } state_e;

    localparam logic [4:0] ST_ID   = 5'b00011;
    localparam logic [4:0] ST_EX   = 5'b00111;
    localparam logic [4:0] ST_DR   = 5'b00011;
    localparam logic [4:0] ST_HALT = 5'b11111;

    localparam logic [MC_W-1:0] DRAIN_N = MC_W'(DRAIN_CYC);
    localparam logic [MC_W-1:0] ONE     = MC_W'(1);

    state_e            state_q, state_d;
    logic [MC_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic [MC_W-1:0]   n_eff;
    logic [4:0]        stall;
    logic              flush;
    logic              done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = '0;
        flush   = 1'b0;
        done    = 1'b0;
        n_eff   = (mc_cycles_i == '0) ? ONE : mc_cycles_i;
        unique case (state_q)
            RUN: begin
                if (mc_start_i) begin
                    stall = ST_EX;
                    if (n_eff == ONE) begin
                        done = 1'b1;
                    end else begin
                        state_d = MC_BUSY;
                        cnt_d   = n_eff - ONE;
                    end
                end else begin
                    if (stallreq_id_i) stall = ST_ID;
                    if (halt_req_i) begin
                        state_d = HALT_DRAIN;
                        cnt_d   = DRAIN_N;
                    end
                end
                // A stalled ID stage re-evaluates its branch next cycle
                flush = branch_i && (stall == '0);
            end
            MC_BUSY: begin
                stall = ST_EX;
                if (cnt_q <= ONE) begin
                    done    = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            HALT_DRAIN: begin
                stall = ST_DR;
                if (cnt_q <= ONE) begin
                    state_d = HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            HALTED: begin
                stall = ST_HALT;
                if (resume_i) state_d = RUN;
            end
        endcase
        scnt_d = scnt_q;
        if (stall != '0 && scnt_q != '1) scnt_d = scnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
        end
    end

    // Outputs forced low while reset is held, even with live inputs
    assign stall_o     = rst_n ? stall : 5'b0;
    assign flush_o     = rst_n && flush;
    assign new_pc_o    = (rst_n && flush) ? branch_target_i : 32'h0;
    assign mc_done_o   = rst_n && done;
    assign halted_o    = rst_n && (state_q == HALTED);
    assign stall_cnt_o = scnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus random stimulus for pipe_ctrl, checked against a
// cycle-indexed behavioural model of the controller.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        mc_start_i = 1'b0;
    logic [5:0]  mc_cycles_i = '0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        halt_req_i = 1'b0;
    logic        resume_i = 1'b0;
    logic [4:0]  stall_o, stall_s;
    logic        flush_o, flush_s;
    logic [31:0] new_pc_o, new_pc_s;
    logic        mc_done_o, mc_done_s;
    logic        halted_o, halted_s;
    logic [31:0] stall_cnt_o;
    logic [3:0]  stall_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    // model state, expressed as absolute cycle indices
    int     cyc = 0;
    int     mc_end = -1;
    int     drain_end = -1;
    bit     halted_m = 0;
    longint cnt_m = 0;
    int     cnt_s = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_id_i(stallreq_id_i),
        .mc_start_i(mc_start_i), .mc_cycles_i(mc_cycles_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .halt_req_i(halt_req_i), .resume_i(resume_i),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .mc_done_o(mc_done_o), .halted_o(halted_o),
        .stall_cnt_o(stall_cnt_o)
    );

    pipe_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .stallreq_id_i(stallreq_id_i),
        .mc_start_i(mc_start_i), .mc_cycles_i(mc_cycles_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .halt_req_i(halt_req_i), .resume_i(resume_i),
        .stall_o(stall_s), .flush_o(flush_s), .new_pc_o(new_pc_s),
        .mc_done_o(mc_done_s), .halted_o(halted_s),
        .stall_cnt_o(stall_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit mcs, input int mcn, input bit id,
                        input bit br, input logic [31:0] tgt,
                        input bit hr, input bit rs);
        logic [4:0] e_st;
        bit e_fl, e_dn, e_h, h_next;
        int n;
        @(negedge clk);
        mc_start_i = mcs;
        mc_cycles_i = 6'(mcn);
        stallreq_id_i = id;
        branch_i = br;
        branch_target_i = tgt;
        halt_req_i = hr;
        resume_i = rs;
        #1;
        e_st = '0; e_fl = 0; e_dn = 0; e_h = 0;
        h_next = halted_m;
        if (cyc <= mc_end) begin
            e_st = 5'b00111;
            e_dn = (cyc == mc_end);
        end else if (halted_m) begin
            e_st = 5'b11111;
            e_h = 1;
            if (rs) h_next = 0;
        end else if (cyc <= drain_end) begin
            e_st = 5'b00011;
            if (cyc == drain_end) h_next = 1;
        end else begin
            if (mcs) begin
                n = (mcn % 64 == 0) ? 1 : mcn % 64;
                e_st = 5'b00111;
                mc_end = cyc + n - 1;
                e_dn = (n == 1);
            end else begin
                if (id) e_st = 5'b00011;
                if (hr) drain_end = cyc + 3;
            end
            e_fl = br && (e_st == 0);
        end
        chk("stall", 32'(stall_o), 32'(e_st));
        chk("flush", 32'(flush_o), 32'(e_fl));
        if (e_fl) chk("new_pc", new_pc_o, tgt);
        chk("mc_done", 32'(mc_done_o), 32'(e_dn));
        chk("halted", 32'(halted_o), 32'(e_h));
        chk("stall_cnt", stall_cnt_o, 32'(cnt_m));
        chk("stall_cnt_sat", 32'(stall_cnt_s), 32'(cnt_s));
        chk("stall_small", 32'(stall_s), 32'(e_st));
        if (e_st != 0) begin
            if (cnt_m < 64'hFFFF_FFFF) cnt_m++;
            if (cnt_s < 15) cnt_s++;
        end
        halted_m = h_next;
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mc_start_i = 0; stallreq_id_i = 0; branch_i = 0;
        halt_req_i = 0; resume_i = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_done", 32'(mc_done_o), 32'h0);
        chk("rst_cnt", stall_cnt_o, 32'h0);
        chk("rst_halted", 32'(halted_o), 32'h0);
        mc_end = -1; drain_end = -1; halted_m = 0;
        cnt_m = 0; cnt_s = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        idle(2);
        // multi-cycle op, N=4
        step(1, 4, 0, 0, 0, 0, 0);
        idle(4);
        // N=0 and N=1 complete in one cycle
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 32'h44, 0, 0);
        idle(1);
        // load-use with and without branch
        step(0, 0, 1, 1, 32'h200, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        // clean branch redirect
        step(0, 0, 0, 1, 32'h0000_0100, 0, 0);
        idle(1);
        // halt, drain, resume
        step(0, 0, 0, 1, 32'h300, 1, 0);
        idle(4);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // halt during MC_BUSY is deferred
        step(1, 5, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
        idle(4);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // async reset mid MC_BUSY
        step(1, 6, 0, 0, 0, 0, 0);
        idle(2);
        do_reset();
        idle(2);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
